mul_rf_seq: RTL and testbench
=============================

Name: mul_rf_seq

Overview:
Iterative RV32M multiply unit; the initiator on the register-file port.
- Drives read indices and captures operands.
- Computes a 64-bit product by radix-2 shift-add.
- Writes the selected 32-bit half back through the RF write port.
- Sits between the decode stage (issues start) and the RF (rs1/rs2/rd/we/rwdata interface).

Parameters:
XLEN, 32, operand/result width; ITER = XLEN iterations.
REGW, 5, register index width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  issue request from decode; sampled only in IDLE
op  in  2  00 MUL (low), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
rs1_idx  in  REGW  source 1 index from decode
rs2_idx  in  REGW  source 2 index from decode
rd_idx  in  REGW  destination index from decode
rf_rs1  out  REGW  RF read index 1
rf_rs2  out  REGW  RF read index 2
rf_rv1  in  XLEN  RF read data 1 (combinational read)
rf_rv2  in  XLEN  RF read data 2 (combinational read)
rf_rd  out  REGW  RF write index
rf_we  out  1  RF write enable
rf_wdata  out  XLEN  RF write data
busy  out  1  high from cycle after accepted start through WB
done  out  1  one-cycle pulse coincident with WB

Behaviour:
Reset:
- state=IDLE; busy=0, done=0, rf_we=0.
- rf_rs1/rf_rs2/rf_rd=0, rf_wdata=0.
- All internal registers cleared.
- Reset asserted mid-operation aborts immediately: no write issued, next cycle is IDLE.

States: IDLE -> READ -> CALC -> WB -> IDLE.

IDLE:
- start=1 latches op, rs1_idx, rs2_idx, rd_idx; next READ.
- start=0 stays IDLE.

READ (1 cycle):
- rf_rs1/rf_rs2 driven from latched indices; rf_rv1/rf_rv2 captured at end of cycle.
- Signedness: a_neg = rv1[31] & (op==MULH|MULHSU); b_neg = rv2[31] & (op==MULH).
- Magnitudes stored as unsigned 32-bit. abs(0x80000000) = 0x80000000, representable unsigned.
- neg = a_neg ^ b_neg.

CALC (exactly ITER=32 cycles):
- Each cycle: if multiplier LSB=1, add multiplicand to upper accumulator (33-bit sum, carry kept); shift {carry, acc} right 1.
- 6-bit counter counts 0..31; leaves CALC when counter==31.

WB (1 cycle):
- If neg, product = two's complement of the 64-bit product.
- rf_wdata = product[31:0] for MUL, else product[63:32].
- rf_rd = latched rd; done=1.
- rf_we=1 unless latched rd==0 (write to x0 suppressed; done still pulses).
- Next cycle: IDLE, rf_we=0.

Timing and handshake:
- Latency from accepted start (cycle T): write occurs at T+34. Throughput: one op per 35 cycles.
- busy=1 in READ, CALC and WB; it is a registered output.
- start while busy is ignored; not queued.
- start in the WB cycle is ignored. A new start is accepted in the IDLE cycle after WB.
- Source index == destination index is legal: operands are captured in READ, before WB.
- rf_rs1/rf_rs2 hold the last latched values outside READ. rf_wdata holds its value after WB; only rf_we qualifies it.

Decomposition:
Shared package mul_pkg:
- op encodings: OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU.
- State encoding: IDLE, READ, CALC, WB.
- XLEN and REGW constants.

Sub-module mul_shift_add:
- Holds the accumulator, multiplier shift register and iteration counter.
- Controls: load, step. Outputs: last, product[63:0].
- Top level keeps the FSM, sign handling and RF port drive.

Test Plan:
- MUL, x1=7, x2=6, rd=3, start at T -> rf_we=1 at T+34, rf_rd=3, rf_wdata=0x0000002A, done pulse 1 cycle, busy low at T+35.
- MULH, x1=0xFFFFFFFF (-1), x2=0x00000002 -> wdata=0xFFFFFFFF. Same operands with MULHU -> 0x00000001. With MULHSU -> 0xFFFFFFFF.
- MULH, x1=x2=0x80000000 -> wdata=0x40000000. Same operands with MUL -> 0x00000000.
- rd=0, MUL, 5×5 -> done pulses at T+34, rf_we stays 0 throughout.
- Second start at T+10 (busy) -> ignored, single write at T+34. Start at T+35 -> accepted, write at T+69.
- rst asserted at T+20 -> IDLE next cycle, busy=0, no rf_we ever asserted for that op. Start after reset -> normal 34-cycle completion.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and encodings for the iterative RV32M multiply unit.
// Imported by the shift-add datapath and the RF-facing controller.
package mul_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int ITER = XLEN;
  localparam int CNTW = 6;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    CALC = 2'b10,
    WB   = 2'b11
  } state_e;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                              input logic            neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add multiplier core: unsigned 32x32 -> 64 in ITER steps.
// The product is {acc, multiplier}; the multiplier register fills with result bits.
module mul_shift_add
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [XLEN-1:0]   mcand_i,
  input  logic [XLEN-1:0]   mplier_i,
  output logic              last_o,
  output logic [2*XLEN-1:0] product_o
);

  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] mpl_q;
  logic [CNTW-1:0] cnt_q;
  logic [XLEN:0]   sum_d;

  // Carry is kept in bit XLEN and shifted back into the accumulator.
  always_comb begin
    sum_d = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, mcand_q} : '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mpl_q   <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      mcand_q <= mcand_i;
      acc_q   <= '0;
      mpl_q   <= mplier_i;
      cnt_q   <= '0;
    end else if (step_i) begin
      acc_q   <= sum_d[XLEN:1];
      mpl_q   <= {sum_d[0], mpl_q[XLEN-1:1]};
      cnt_q   <= cnt_q + CNTW'(1);
    end
  end

  assign last_o    = (cnt_q == CNTW'(ITER - 1));
  assign product_o = {acc_q, mpl_q};

endmodule

// File: rtl/mul_rf_seq.sv
// RV32M multiply unit acting as register-file initiator: read operands,
// run the shift-add core, then write the selected product half back.
module mul_rf_seq
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [REGW-1:0] rs1_idx,
  input  logic [REGW-1:0] rs2_idx,
  input  logic [REGW-1:0] rd_idx,
  output logic [REGW-1:0] rf_rs1,
  output logic [REGW-1:0] rf_rs2,
  input  logic [XLEN-1:0] rf_rv1,
  input  logic [XLEN-1:0] rf_rv2,
  output logic [REGW-1:0] rf_rd,
  output logic            rf_we,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic            done
);

  state_e          state_q;
  mul_op_e         op_q;
  logic [REGW-1:0] rs1_q, rs2_q, rd_q;
  logic            neg_q;
  logic            busy_q, done_q, we_q;
  logic [XLEN-1:0] wdata_q;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              last;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   wdata_d;

  // NOTE: every always_comb output is assigned on all paths, so no latch forms.
  always_comb begin
    a_neg    = rf_rv1[XLEN-1] & ((op_q == OP_MULH) | (op_q == OP_MULHSU));
    b_neg    = rf_rv2[XLEN-1] & (op_q == OP_MULH);
    a_mag    = abs_val(rf_rv1, a_neg);
    b_mag    = abs_val(rf_rv2, b_neg);
    prod_fix = neg_q ? (~product + (2*XLEN)'(1)) : product;
    wdata_d  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  mul_shift_add u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (state_q == READ),
    .step_i    (state_q == CALC),
    .mcand_i   (a_mag),
    .mplier_i  (b_mag),
    .last_o    (last),
    .product_o (product)
  );

  // NOTE: every register, including the latched operands, is cleared on reset
  // so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= mul_op_e'(op);
            rs1_q   <= rs1_idx;
            rs2_q   <= rs2_idx;
            rd_q    <= rd_idx;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          neg_q   <= a_neg ^ b_neg;
          state_q <= CALC;
        end
        CALC: begin
          if (last) begin
            done_q  <= 1'b1;
            we_q    <= (rd_q != '0);
            state_q <= WB;
          end
        end
        WB: begin
          wdata_q <= wdata_d;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // During WB the freshly finished product is presented; afterwards it is held.
  assign rf_wdata = (state_q == WB) ? wdata_d : wdata_q;
  assign rf_rs1   = rs1_q;
  assign rf_rs2   = rs2_q;
  assign rf_rd    = rd_q;
  assign rf_we    = we_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mul_rf_seq.sv
// Directed and random checks of mul_rf_seq against a behavioural register file
// and a scoreboard of expected write-backs keyed by completion cycle.
module tb_mul_rf_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [31:0] rf_rv1, rf_rv2, rf_wdata;
  logic        rf_we, busy, done;

  logic [31:0] regs [32];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_rv1 = regs[rf_rs1];
  assign rf_rv2 = regs[rf_rs2];

  mul_rf_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_idx  (rs1_idx),
    .rs2_idx  (rs2_idx),
    .rd_idx   (rd_idx),
    .rf_rs1   (rf_rs1),
    .rf_rs2   (rf_rs2),
    .rf_rv1   (rf_rv1),
    .rf_rv2   (rf_rv2),
    .rf_rd    (rf_rd),
    .rf_we    (rf_we),
    .rf_wdata (rf_wdata),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [31:0] ref_mul(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drives start for one cycle starting at a negedge; an accepted request
  // is expected to write back 34 cycles later.
  task automatic issue(logic [1:0] o, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                       logic accept, logic [31:0] data);
    start = 1'b1; op = o; rs1_idx = a; rs2_idx = b; rd_idx = d;
    if (accept) sb.push_back('{cyc: cyc + 34, rd: d, we: (d != 5'd0), data: data});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int t;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    foreach (regs[i]) regs[i] = 32'h0;
    rst = 1'b1; start = 1'b0; op = 2'b00;
    rs1_idx = '0; rs2_idx = '0; rd_idx = '0;

    fork
      begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
      end
      forever begin
        @(negedge clk);
        check("we_without_done", 64'(rf_we & ~done), 64'd0);
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("wb_cycle", 64'(cyc), 64'(e.cyc));
            check("wb_rd", 64'(rf_rd), 64'(e.rd));
            check("wb_we", 64'(rf_we), 64'(e.we));
            check("wb_data", 64'(rf_wdata), 64'(e.data));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_outputs", {rf_rs1, rf_rs2, rf_rd, rf_wdata, rf_we, busy, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MUL 7*6 into x3, with busy timing around the operation
    regs[1] = 32'd7; regs[2] = 32'd6;
    t = cyc;
    issue(2'b00, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0000_002A);
    check("busy_in_read", 64'(busy), 64'd1);
    wait_until(t + 34);
    check("busy_in_wb", 64'(busy), 64'd1);
    wait_until(t + 35);
    check("busy_after_wb", 64'(busy), 64'd0);
    drain(5);

    // sign handling: -1 * 2
    regs[4] = 32'hFFFF_FFFF; regs[5] = 32'h0000_0002;
    issue(2'b01, 5'd4, 5'd5, 5'd6, 1'b1, 32'hFFFF_FFFF); drain(60);
    issue(2'b11, 5'd4, 5'd5, 5'd6, 1'b1, 32'h0000_0001); drain(60);
    issue(2'b10, 5'd4, 5'd5, 5'd6, 1'b1, 32'hFFFF_FFFF); drain(60);

    // most-negative operands
    regs[7] = 32'h8000_0000; regs[8] = 32'h8000_0000;
    issue(2'b01, 5'd7, 5'd8, 5'd9, 1'b1, 32'h4000_0000); drain(60);
    issue(2'b00, 5'd7, 5'd8, 5'd9, 1'b1, 32'h0000_0000); drain(60);

    // write to x0 is suppressed but still completes
    regs[10] = 32'd5;
    issue(2'b00, 5'd10, 5'd10, 5'd0, 1'b1, 32'd25); drain(60);

    // starts while busy and during WB are ignored; start right after WB accepted
    regs[11] = 32'd1000; regs[12] = 32'd3; regs[13] = 32'd9;
    t = cyc;
    issue(2'b00, 5'd11, 5'd12, 5'd14, 1'b1, 32'd3000);
    wait_until(t + 10);
    issue(2'b00, 5'd13, 5'd13, 5'd15, 1'b0, 32'd0);
    wait_until(t + 34);
    issue(2'b00, 5'd13, 5'd12, 5'd16, 1'b0, 32'd0);
    wait_until(t + 35);
    issue(2'b00, 5'd13, 5'd13, 5'd17, 1'b1, 32'd81);
    drain(60);

    // reset mid-operation aborts without a write
    t = cyc;
    issue(2'b00, 5'd11, 5'd12, 5'd18, 1'b1, 32'd3000);
    wait_until(t + 20);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_idle", {busy, done, rf_we}, 64'd0);
    repeat (40) @(negedge clk);
    issue(2'b00, 5'd1, 5'd2, 5'd19, 1'b1, 32'd42); drain(60);

    // random operands and ops against the reference model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      ro = 2'($urandom_range(0, 3));
      regs[20] = ra; regs[21] = rb;
      issue(ro, 5'd20, 5'd21, 5'd22, 1'b1, ref_mul(ro, ra, rb));
      drain(60);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
